// File: rtl/pe_row_feeder.sv
// -----------------------------------------------------------------------------
// pe_row_feeder
//   Feeds the west/preload edge of a systolic PE array. One tile is K operand
//   vectors taken over a valid/ready stream, preceded by a single preload beat.
//   Every lane has its own register chain, so lane i lags lane 0 by i cycles
//   (the diagonal skew). The propagate flag flips once per tile, which makes
//   the PE double buffers swap on tile boundaries.
//
// Ports
//   clock                    rising-edge clock
//   reset_n                  asynchronous active-low reset
//   start                    begin a tile (sampled only in IDLE)
//   k_len                    number of vectors in the tile (captured with start)
//   d_data                   per-lane preload values (captured with start)
//   s_valid/s_ready/s_data   operand vector stream, lane i = s_data[i*DATA_W +: DATA_W]
//   io_in_a                  skewed operands to the array
//   io_in_d                  skewed preload (0 outside the preload beat)
//   io_in_control_propagate  skewed per-lane propagate flag
//   busy                     high in PRELOAD, STREAM and FLUSH
//   done                     one-cycle registered pulse in the first IDLE cycle
// -----------------------------------------------------------------------------
module pe_row_feeder #(
  parameter int LANES  = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 5
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [CNT_W-1:0]        k_len,
  input  logic [LANES*ACC_W-1:0]  d_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [LANES*DATA_W-1:0] s_data,
  output logic [LANES*DATA_W-1:0] io_in_a,
  output logic [LANES*ACC_W-1:0]  io_in_d,
  output logic [LANES-1:0]        io_in_control_propagate,
  output logic                    busy,
  output logic                    done
);

  // Flush counter must hold LANES-2 (the last flush cycle index).
  localparam int FL_W = (LANES > 2) ? $clog2(LANES - 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRELOAD,
    S_STREAM,
    S_FLUSH
  } state_e;

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [FL_W-1:0]          fl_q, fl_d;
  logic [CNT_W-1:0]         k_q, k_d;
  logic [LANES*ACC_W-1:0]   dl_q, dl_d;
  logic                     prop_q, prop_d;
  logic                     done_q, done_d;

  logic                     hs;
  logic [LANES*DATA_W-1:0]  a_in;
  logic [LANES*ACC_W-1:0]   d_in;

  assign s_ready = (state_q == S_STREAM) && (cnt_q < k_q);
  assign hs      = s_valid && s_ready;
  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;

  // Skew-line stage 0 inputs. A bubble in STREAM becomes a zero vector, and the
  // propagate input uses the next flag value so the flip enters with the preload.
  assign a_in = hs ? s_data : '0;
  assign d_in = (state_q == S_PRELOAD) ? dl_q : '0;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    fl_d    = fl_q;
    k_d     = k_q;
    dl_d    = dl_q;
    prop_d  = prop_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && (k_len != '0)) begin
          state_d = S_PRELOAD;
          k_d     = k_len;
          dl_d    = d_data;
        end
      end
      S_PRELOAD: begin
        state_d = S_STREAM;
        cnt_d   = '0;
        prop_d  = ~prop_q;
      end
      S_STREAM: begin
        if (hs) begin
          cnt_d = cnt_q + 1'b1;
          if ((cnt_q + 1'b1) == k_q) begin
            state_d = S_FLUSH;
            fl_d    = '0;
          end
        end
      end
      S_FLUSH: begin
        if (fl_q == FL_W'(LANES - 2)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          fl_d = fl_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      fl_q    <= '0;
      k_q     <= '0;
      dl_q    <= '0;
      prop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fl_q    <= fl_d;
      k_q     <= k_d;
      dl_q    <= dl_d;
      prop_q  <= prop_d;
      done_q  <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Skew line: lane g is a (g+1)-stage chain shifting every cycle.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [DATA_W-1:0] a_q [0:g];
    logic [ACC_W-1:0]  d_q [0:g];
    logic [g:0]        p_q;

    always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: the skew stages are cleared on reset (unlike a RAM) because their
      // contents drive the array outputs directly and must read 0 in reset.
      if (!reset_n) begin
        for (int k = 0; k <= g; k++) begin
          a_q[k] <= '0;
          d_q[k] <= '0;
        end
        p_q <= '0;
      end else begin
        a_q[0] <= a_in[g*DATA_W +: DATA_W];
        d_q[0] <= d_in[g*ACC_W +: ACC_W];
        p_q[0] <= prop_d;
        for (int k = 1; k <= g; k++) begin
          a_q[k] <= a_q[k-1];
          d_q[k] <= d_q[k-1];
          p_q[k] <= p_q[k-1];
        end
      end
    end

    assign io_in_a[g*DATA_W +: DATA_W]  = a_q[g];
    assign io_in_d[g*ACC_W +: ACC_W]    = d_q[g];
    assign io_in_control_propagate[g]   = p_q[g];
  end

endmodule

// File: tb/tb_pe_row_feeder.sv
// -----------------------------------------------------------------------------
// tb_pe_row_feeder
//   Directed bench for pe_row_feeder (LANES=4, DATA_W=8, ACC_W=16, CNT_W=5).
//   Cycle c is the interval right after clock edge c of a tile; start is driven
//   in cycle 0. Each tile records the outputs of every cycle into trace arrays,
//   which are then compared against hand-derived expectations.
// -----------------------------------------------------------------------------
module tb_pe_row_feeder;

  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 5;
  localparam int NC     = 24;

  logic                    clock   = 1'b0;
  logic                    reset_n = 1'b1;
  logic                    start   = 1'b0;
  logic [CNT_W-1:0]        k_len   = '0;
  logic [LANES*ACC_W-1:0]  d_data  = '0;
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic [LANES*DATA_W-1:0] s_data  = '0;
  logic [LANES*DATA_W-1:0] io_in_a;
  logic [LANES*ACC_W-1:0]  io_in_d;
  logic [LANES-1:0]        io_in_control_propagate;
  logic                    busy;
  logic                    done;

  pe_row_feeder #(
    .LANES (LANES),
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock                  (clock),
    .reset_n                (reset_n),
    .start                  (start),
    .k_len                  (k_len),
    .d_data                 (d_data),
    .s_valid                (s_valid),
    .s_ready                (s_ready),
    .s_data                 (s_data),
    .io_in_a                (io_in_a),
    .io_in_d                (io_in_d),
    .io_in_control_propagate(io_in_control_propagate),
    .busy                   (busy),
    .done                   (done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Per-cycle stimulus and the hand-marked cycles where a handshake must occur.
  bit          stim_start [NC];
  bit          stim_valid [NC];
  logic [31:0] stim_data  [NC];
  bit          exp_hs     [NC];

  // Recorded outputs per cycle.
  logic [31:0] tr_a    [NC];
  logic [63:0] tr_d    [NC];
  logic [3:0]  tr_p    [NC];
  logic        tr_busy [NC];
  logic        tr_rdy  [NC];
  logic        tr_done [NC];

  localparam logic [63:0] D_T2 = 64'h1003_1002_1001_1000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int c = 0; c < NC; c++) begin
      stim_start[c] = 1'b0;
      stim_valid[c] = 1'b0;
      stim_data[c]  = '0;
      exp_hs[c]     = 1'b0;
    end
  endtask

  // Entered and left #1 after a rising edge.
  task automatic run_tile(input int klen, input logic [63:0] dd, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      start   = stim_start[c];
      k_len   = CNT_W'(klen);
      d_data  = dd;
      s_valid = stim_valid[c];
      s_data  = stim_data[c];
      #1;
      tr_a[c]    = io_in_a;
      tr_d[c]    = io_in_d;
      tr_p[c]    = io_in_control_propagate;
      tr_busy[c] = busy;
      tr_rdy[c]  = s_ready;
      tr_done[c] = done;
      @(posedge clock);
      #1;
    end
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  // Lane i at cycle c carries byte i of whatever was handshaken in cycle c-1-i.
  function automatic logic [31:0] exp_a(input int c);
    logic [31:0] r;
    logic [31:0] v;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      int src;
      src = c - 1 - i;
      if (src >= 0 && exp_hs[src]) begin
        v = stim_data[src];
        r[i*8 +: 8] = v[i*8 +: 8];
      end
    end
    return r;
  endfunction

  // k_len=3, three back-to-back vectors, valid early (not accepted), an extra
  // valid after the last one (not accepted), start repeated while busy.
  task automatic setup_t2();
    clear_stim();
    stim_start[0] = 1'b1;
    stim_start[3] = 1'b1;
    stim_valid[1] = 1'b1; stim_data[1] = 32'h0403_0201;
    stim_valid[2] = 1'b1; stim_data[2] = 32'h0403_0201;
    stim_valid[3] = 1'b1; stim_data[3] = 32'h0807_0605;
    stim_valid[4] = 1'b1; stim_data[4] = 32'h0C0B_0A09;
    stim_valid[5] = 1'b1; stim_data[5] = 32'hFFFF_FFFF;
    exp_hs[2] = 1'b1;
    exp_hs[3] = 1'b1;
    exp_hs[4] = 1'b1;
  endtask

  // Checks for a first tile after reset (propagate ripples 0 -> 1).
  task automatic chk_t2(input string pfx);
    logic [63:0] ed;
    logic [3:0]  ep;
    for (int c = 0; c <= 10; c++) begin
      ed = '0;
      ep = '0;
      for (int i = 0; i < LANES; i++) begin
        if (c == 2 + i) ed[i*16 +: 16] = 16'h1000 + 16'(i);
        ep[i] = (c >= 2 + i);
      end
      check($sformatf("%s busy c%0d", pfx, c), 64'(tr_busy[c]), 64'(c >= 1 && c <= 7));
      check($sformatf("%s s_ready c%0d", pfx, c), 64'(tr_rdy[c]), 64'(c >= 2 && c <= 4));
      check($sformatf("%s done c%0d", pfx, c), 64'(tr_done[c]), 64'(c == 8));
      check($sformatf("%s io_in_a c%0d", pfx, c), 64'(tr_a[c]), 64'(exp_a(c)));
      check($sformatf("%s io_in_d c%0d", pfx, c), tr_d[c], ed);
      check($sformatf("%s prop c%0d", pfx, c), 64'(tr_p[c]), 64'(ep));
    end
    // Explicit spot checks of the skew corners.
    check($sformatf("%s lane0 c3", pfx), 64'(tr_a[3][7:0]), 64'h01);
    check($sformatf("%s lane0 c5", pfx), 64'(tr_a[5][7:0]), 64'h09);
    check($sformatf("%s lane3 c6", pfx), 64'(tr_a[6][31:24]), 64'h04);
    check($sformatf("%s lane3 c8", pfx), 64'(tr_a[8][31:24]), 64'h0C);
  endtask

  task automatic chk_all_zero(input string pfx);
    check({pfx, " io_in_a"}, 64'(io_in_a), 64'h0);
    check({pfx, " io_in_d"}, io_in_d, 64'h0);
    check({pfx, " prop"}, 64'(io_in_control_propagate), 64'h0);
    check({pfx, " busy"}, 64'(busy), 64'h0);
    check({pfx, " s_ready"}, 64'(s_ready), 64'h0);
    check({pfx, " done"}, 64'(done), 64'h0);
  endtask

  initial begin
    logic [3:0] ep;

    // Reset takes effect without a clock edge.
    #2 reset_n = 1'b0;
    #1 chk_all_zero("reset0");
    #10 reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Tile 1: back-to-back vectors, preload values, propagate 0 -> 1.
    setup_t2();
    run_tile(3, D_T2, 11);
    chk_t2("t2");

    // Tile 2: k_len=2 with a two-cycle bubble, propagate 1 -> 0.
    clear_stim();
    stim_start[0] = 1'b1;
    stim_start[4] = 1'b1;
    stim_valid[1] = 1'b1; stim_data[1] = 32'h1413_1211;
    stim_valid[2] = 1'b1; stim_data[2] = 32'h1413_1211;
    stim_valid[3] = 1'b0; stim_data[3] = 32'hEEEE_EEEE;
    stim_valid[4] = 1'b0; stim_data[4] = 32'hEEEE_EEEE;
    stim_valid[5] = 1'b1; stim_data[5] = 32'h2423_2221;
    stim_valid[6] = 1'b1; stim_data[6] = 32'hFFFF_FFFF;
    exp_hs[2] = 1'b1;
    exp_hs[5] = 1'b1;
    run_tile(2, 64'h0, 12);
    for (int c = 0; c <= 11; c++) begin
      ep = '0;
      for (int i = 0; i < LANES; i++) ep[i] = (c < 2 + i);
      check($sformatf("t3 busy c%0d", c), 64'(tr_busy[c]), 64'(c >= 1 && c <= 8));
      check($sformatf("t3 s_ready c%0d", c), 64'(tr_rdy[c]), 64'(c >= 2 && c <= 5));
      check($sformatf("t3 done c%0d", c), 64'(tr_done[c]), 64'(c == 9));
      check($sformatf("t3 io_in_a c%0d", c), 64'(tr_a[c]), 64'(exp_a(c)));
      check($sformatf("t3 io_in_d c%0d", c), tr_d[c], 64'h0);
      check($sformatf("t3 prop c%0d", c), 64'(tr_p[c]), 64'(ep));
    end

    // start with k_len=0 is ignored: nothing moves, no done.
    clear_stim();
    stim_start[0] = 1'b1;
    stim_valid[1] = 1'b1; stim_data[1] = 32'h5555_5555;
    run_tile(0, 64'h1, 6);
    for (int c = 0; c < 6; c++) begin
      check($sformatf("k0 busy c%0d", c), 64'(tr_busy[c]), 64'h0);
      check($sformatf("k0 s_ready c%0d", c), 64'(tr_rdy[c]), 64'h0);
      check($sformatf("k0 done c%0d", c), 64'(tr_done[c]), 64'h0);
      check($sformatf("k0 io_in_a c%0d", c), 64'(tr_a[c]), 64'h0);
      check($sformatf("k0 prop c%0d", c), 64'(tr_p[c]), 64'h0);
    end

    // Reset in the middle of STREAM, then a fresh tile behaves like tile 1.
    setup_t2();
    run_tile(3, D_T2, 4);
    check("mid busy before reset", 64'(busy), 64'h1);
    #2 reset_n = 1'b0;
    #1 chk_all_zero("reset mid");
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    setup_t2();
    run_tile(3, D_T2, 11);
    chk_t2("rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
